// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared FSM encoding, standard CRC presets and bit-reverse helpers
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } crc_state_e;

  localparam logic [31:0] CRC32_POLY         = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT         = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_MPEG2_POLY   = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_MPEG2_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_MPEG2_XOROUT = 32'h0000_0000;
  localparam logic [15:0] CRC16_CCITT_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_CCITT_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_CCITT_XOROUT = 16'h0000;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reverses the low w bits of x; result is right-aligned.
  function automatic logic [31:0] rev_w(input logic [31:0] x, input int unsigned w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r >> (32 - w);
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// rtl/crc_byte_step.sv - folds one byte into a CRC register, MSB-first, eight unrolled shifts
module crc_byte_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] crc,
  input  logic [7:0]   data_byte,
  input  logic [W-1:0] poly,
  output logic [W-1:0] crc_next
);

  logic [W-1:0] work;

  always_comb begin
    work = crc;
    for (int i = 0; i < 8; i++) begin
      if (work[W-1] ^ data_byte[7-i]) work = (work << 1) ^ poly;
      else                            work = work << 1;
    end
    crc_next = work;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - one-frame-at-a-time CRC over 32-bit beats, four byte steps per cycle
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 32
) (
  input  logic                  crc_clk,
  input  logic                  crc_rst,
  input  logic [CRC_WIDTH-1:0]  cfg_poly,
  input  logic [CRC_WIDTH-1:0]  cfg_init,
  input  logic [CRC_WIDTH-1:0]  cfg_xorout,
  input  logic                  cfg_refin,
  input  logic                  cfg_refout,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic [3:0]            s_keep,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic [31:0]           byte_cnt,
  output logic                  busy,
  output logic                  keep_err
);

  crc_state_e state, state_next;

  logic [CRC_WIDTH-1:0] crc_q, poly_q, xorout_q;
  logic                 refin_q, refout_q;
  logic                 cfg_ld, beat_acc, out_ld;
  logic [3:0]           lane_en;
  logic [2:0]           lane_cnt;
  logic                 keep_bad;
  logic [CRC_WIDTH-1:0] chain [5];
  logic [CRC_WIDTH-1:0] crc_fold, crc_final;
  logic [31:0]          fold_rev;

  // Only the run of enabled lanes starting at lane 0 is folded.
  assign lane_en  = {&s_keep[3:0], &s_keep[2:0], &s_keep[1:0], s_keep[0]};
  assign lane_cnt = {2'b0, lane_en[0]} + {2'b0, lane_en[1]} + {2'b0, lane_en[2]} + {2'b0, lane_en[3]};
  assign keep_bad = (s_keep != lane_en);

  assign chain[0] = crc_q;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0]           lane_byte;
    logic [CRC_WIDTH-1:0] stepped;

    assign lane_byte = refin_q ? rev8(s_data[8*g +: 8]) : s_data[8*g +: 8];

    crc_byte_step #(.W(CRC_WIDTH)) u_step (
      .crc       (chain[g]),
      .data_byte (lane_byte),
      .poly      (poly_q),
      .crc_next  (stepped)
    );

    assign chain[g+1] = lane_en[g] ? stepped : chain[g];
  end

  assign crc_fold  = chain[4];
  assign fold_rev  = rev_w(32'(crc_fold), CRC_WIDTH);
  assign crc_final = (refout_q ? fold_rev[CRC_WIDTH-1:0] : crc_fold) ^ xorout_q;

  always_ff @(posedge crc_clk or posedge crc_rst) begin
    if (crc_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    busy       = 1'b0;
    cfg_ld     = 1'b0;
    beat_acc   = 1'b0;
    out_ld     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          cfg_ld     = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        s_ready  = 1'b1;
        busy     = 1'b1;
        beat_acc = s_valid;
        if (s_valid && s_last) begin
          out_ld     = 1'b1;
          state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        if (m_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Config is captured on start so mid-frame cfg_* changes cannot corrupt the running CRC.
  always_ff @(posedge crc_clk or posedge crc_rst) begin
    if (crc_rst) begin
      crc_q    <= '0;
      poly_q   <= '0;
      xorout_q <= '0;
      refin_q  <= 1'b0;
      refout_q <= 1'b0;
      byte_cnt <= '0;
      keep_err <= 1'b0;
      m_crc    <= '0;
    end else begin
      if (cfg_ld) begin
        crc_q    <= cfg_init;
        poly_q   <= cfg_poly;
        xorout_q <= cfg_xorout;
        refin_q  <= cfg_refin;
        refout_q <= cfg_refout;
        byte_cnt <= '0;
        keep_err <= 1'b0;
      end
      if (beat_acc) begin
        crc_q    <= crc_fold;
        byte_cnt <= byte_cnt + 32'(lane_cnt);
        if (keep_bad) keep_err <= 1'b1;
      end
      if (out_ld) m_crc <= crc_final;
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - scoreboard bench for crc_stream_engine (32-bit and 16-bit instances)
module tb_crc_stream_engine;
  import crc_pkg::*;

  logic crc_clk = 1'b0;
  logic crc_rst = 1'b1;
  always #5 crc_clk = ~crc_clk;

  logic [31:0] cfg_poly = '0, cfg_init = '0, cfg_xorout = '0;
  logic        cfg_refin = 1'b0, cfg_refout = 1'b0;
  logic [31:0] s_data = '0;
  logic [3:0]  s_keep = '0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b1;

  logic        start_a = 1'b0, s_valid_a = 1'b0;
  logic        s_ready_a, m_valid_a, busy_a, keep_err_a;
  logic [31:0] m_crc_a, byte_cnt_a;

  logic        start_b = 1'b0, s_valid_b = 1'b0;
  logic        s_ready_b, m_valid_b, busy_b, keep_err_b;
  logic [15:0] m_crc_b;
  logic [31:0] byte_cnt_b;

  crc_stream_engine #(.DATA_WIDTH(32), .CRC_WIDTH(32)) dut_a (
    .crc_clk(crc_clk), .crc_rst(crc_rst),
    .cfg_poly(cfg_poly), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
    .cfg_refin(cfg_refin), .cfg_refout(cfg_refout),
    .start(start_a), .s_valid(s_valid_a), .s_ready(s_ready_a),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_crc(m_crc_a),
    .byte_cnt(byte_cnt_a), .busy(busy_a), .keep_err(keep_err_a)
  );

  crc_stream_engine #(.DATA_WIDTH(32), .CRC_WIDTH(16)) dut_b (
    .crc_clk(crc_clk), .crc_rst(crc_rst),
    .cfg_poly(cfg_poly[15:0]), .cfg_init(cfg_init[15:0]), .cfg_xorout(cfg_xorout[15:0]),
    .cfg_refin(cfg_refin), .cfg_refout(cfg_refout),
    .start(start_b), .s_valid(s_valid_b), .s_ready(s_ready_b),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_crc(m_crc_b),
    .byte_cnt(byte_cnt_b), .busy(busy_b), .keep_err(keep_err_b)
  );

  typedef struct {
    logic [31:0] crc;
    logic [31:0] cnt;
    logic        kerr;
  } exp_t;

  typedef logic [7:0] byte_q_t [$];

  exp_t        q_a[$], q_b[$];
  exp_t        e_a, e_b;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] fr_data[$];
  logic [3:0]  fr_keep[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Bit-serial long division over the message bit stream.
  function automatic logic [31:0] model_crc(input byte_q_t bytes, input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xorout, input bit refin, input bit refout);
    logic [31:0] mask, r, o;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r    = init & mask;
    foreach (bytes[k]) begin
      for (int j = 0; j < 8; j++) begin
        bit b, top;
        b   = refin ? bytes[k][j] : bytes[k][7-j];
        top = r[w-1] ^ b;
        r   = ((r << 1) & mask) ^ (top ? (poly & mask) : 32'd0);
      end
    end
    o = r;
    if (refout) for (int j = 0; j < w; j++) o[j] = r[w-1-j];
    return (o ^ xorout) & mask;
  endfunction

  always @(negedge crc_clk) begin
    if (!crc_rst && m_valid_a && m_ready) begin
      if (q_a.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result_a: got %h expected none", m_crc_a);
      end else begin
        e_a = q_a.pop_front();
        check("crc_a", m_crc_a, e_a.crc);
        check("byte_cnt_a", byte_cnt_a, e_a.cnt);
        check("keep_err_a", {31'b0, keep_err_a}, {31'b0, e_a.kerr});
      end
    end
  end

  always @(negedge crc_clk) begin
    if (!crc_rst && m_valid_b && m_ready) begin
      if (q_b.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result_b: got %h expected none", m_crc_b);
      end else begin
        e_b = q_b.pop_front();
        check("crc_b", {16'h0, m_crc_b}, e_b.crc);
        check("byte_cnt_b", byte_cnt_b, e_b.cnt);
        check("keep_err_b", {31'b0, keep_err_b}, {31'b0, e_b.kerr});
      end
    end
  end

  task automatic set_valid(input bit use_b, input logic v);
    if (use_b) s_valid_b = v;
    else       s_valid_a = v;
  endtask

  task automatic set_start(input bit use_b, input logic v);
    if (use_b) start_b = v;
    else       start_a = v;
  endtask

  task automatic send_frame(input bit use_b, input int max_gap, input bit hold_out,
                            input bit idle_junk, input bit has_known, input logic [31:0] known);
    byte_q_t bq;
    exp_t    e;
    int      t, lane;
    int      w;
    w      = use_b ? 16 : 32;
    e.kerr = 1'b0;
    foreach (fr_data[i]) begin
      lane = 0;
      while (lane < 4 && fr_keep[i][lane]) begin
        bq.push_back(fr_data[i][8*lane +: 8]);
        lane++;
      end
      for (int l = lane; l < 4; l++) if (fr_keep[i][l]) e.kerr = 1'b1;
    end
    e.cnt = 32'(bq.size());
    e.crc = has_known ? known : model_crc(bq, w, cfg_poly, cfg_init, cfg_xorout, cfg_refin, cfg_refout);
    if (use_b) q_b.push_back(e);
    else       q_a.push_back(e);

    if (idle_junk) begin
      s_data = 32'hDEAD_BEEF; s_keep = 4'hF; s_last = 1'b1;
      set_valid(use_b, 1'b1);
      repeat (3) @(negedge crc_clk);
      set_valid(use_b, 1'b0);
      s_last = 1'b0;
    end

    set_start(use_b, 1'b1);
    @(negedge crc_clk);
    set_start(use_b, 1'b0);
    check("keep_err_after_start", {31'b0, use_b ? keep_err_b : keep_err_a}, 32'd0);
    cfg_poly = $urandom; cfg_init = $urandom; cfg_xorout = $urandom;
    cfg_refin = 1'($urandom); cfg_refout = 1'($urandom);

    foreach (fr_data[i]) begin
      if (hold_out && i == fr_data.size() - 1) m_ready = 1'b0;
      s_data = fr_data[i];
      s_keep = fr_keep[i];
      s_last = (i == fr_data.size() - 1);
      set_valid(use_b, 1'b1);
      t = 0;
      while (!(use_b ? s_ready_b : s_ready_a) && t < 50) begin
        @(negedge crc_clk);
        t++;
      end
      if (t >= 50) begin
        n_checks++;
        $display("FAIL s_ready_timeout: got 0 expected 1");
      end
      @(negedge crc_clk);
      set_valid(use_b, 1'b0);
      s_last = 1'b0;
      repeat ($urandom_range(0, max_gap)) @(negedge crc_clk);
    end

    if (hold_out) begin
      for (int c = 0; c < 20; c++) begin
        check("hold_m_valid", {31'b0, m_valid_a}, 32'd1);
        check("hold_m_crc", m_crc_a, e.crc);
        start_a = (c == 10);
        @(negedge crc_clk);
      end
      start_a = 1'b0;
      m_ready = 1'b1;
    end

    t = 0;
    while ((use_b ? q_b.size() : q_a.size()) != 0 && t < 100) begin
      @(negedge crc_clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL result_timeout: got none expected %h", e.crc);
    end
    @(negedge crc_clk);
    check("busy_after_result", {31'b0, use_b ? busy_b : busy_a}, 32'd0);
  endtask

  task automatic cfg_crc32();
    cfg_poly = CRC32_POLY; cfg_init = CRC32_INIT; cfg_xorout = CRC32_XOROUT;
    cfg_refin = 1'b1; cfg_refout = 1'b1;
  endtask

  task automatic load_digits();
    fr_data = '{32'h3433_3231, 32'h3837_3635, 32'h0000_0039};
    fr_keep = '{4'hF, 4'hF, 4'h1};
  endtask

  task automatic random_frame();
    int n;
    fr_data.delete();
    fr_keep.delete();
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) begin
      fr_data.push_back($urandom);
      if (i == n - 1 || $urandom_range(0, 9) < 3) fr_keep.push_back(4'($urandom));
      else                                         fr_keep.push_back(4'hF);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge crc_clk);
    check("rst_m_valid", {31'b0, m_valid_a}, 32'd0);
    check("rst_s_ready", {31'b0, s_ready_a}, 32'd0);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_keep_err", {31'b0, keep_err_a}, 32'd0);
    check("rst_m_crc", m_crc_a, 32'd0);
    check("rst_byte_cnt", byte_cnt_a, 32'd0);
    check("rst_m_crc_b", {16'h0, m_crc_b}, 32'd0);
    check("rst_busy_b", {31'b0, busy_b}, 32'd0);
    crc_rst = 1'b0;
    @(negedge crc_clk);

    cfg_crc32(); load_digits();
    send_frame(1'b0, 0, 1'b0, 1'b1, 1'b1, 32'hCBF4_3926);

    cfg_poly = CRC32_MPEG2_POLY; cfg_init = CRC32_MPEG2_INIT; cfg_xorout = CRC32_MPEG2_XOROUT;
    cfg_refin = 1'b0; cfg_refout = 1'b0; load_digits();
    send_frame(1'b0, 4, 1'b0, 1'b0, 1'b1, 32'h0376_E6E7);

    cfg_poly = {16'h0, CRC16_CCITT_POLY}; cfg_init = {16'h0, CRC16_CCITT_INIT};
    cfg_xorout = {16'h0, CRC16_CCITT_XOROUT}; cfg_refin = 1'b0; cfg_refout = 1'b0; load_digits();
    send_frame(1'b1, 2, 1'b0, 1'b0, 1'b1, 32'h0000_29B1);

    cfg_crc32();
    fr_data = '{32'h1234_5678}; fr_keep = '{4'h0};
    send_frame(1'b0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0000);

    cfg_crc32(); load_digits();
    send_frame(1'b0, 0, 1'b1, 1'b0, 1'b1, 32'hCBF4_3926);

    cfg_crc32();
    fr_data = '{32'h3433_3231, 32'h3837_3635}; fr_keep = '{4'hF, 4'b0101};
    send_frame(1'b0, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    cfg_crc32(); load_digits();
    send_frame(1'b0, 0, 1'b0, 1'b0, 1'b1, 32'hCBF4_3926);

    // Abort a frame with reset, then confirm a clean frame follows.
    cfg_crc32();
    start_a = 1'b1; @(negedge crc_clk); start_a = 1'b0;
    s_data = 32'h3433_3231; s_keep = 4'hF; s_valid_a = 1'b1;
    @(negedge crc_clk);
    s_valid_a = 1'b0;
    crc_rst = 1'b1;
    @(negedge crc_clk);
    check("midrst_busy", {31'b0, busy_a}, 32'd0);
    check("midrst_m_valid", {31'b0, m_valid_a}, 32'd0);
    check("midrst_byte_cnt", byte_cnt_a, 32'd0);
    crc_rst = 1'b0;
    @(negedge crc_clk);
    cfg_crc32(); load_digits();
    send_frame(1'b0, 0, 1'b0, 1'b0, 1'b1, 32'hCBF4_3926);

    for (int f = 0; f < 25; f++) begin
      case ($urandom_range(0, 2))
        0: cfg_crc32();
        1: begin
          cfg_poly = CRC32_MPEG2_POLY; cfg_init = CRC32_MPEG2_INIT; cfg_xorout = CRC32_MPEG2_XOROUT;
          cfg_refin = 1'b0; cfg_refout = 1'b0;
        end
        default: begin
          cfg_poly = $urandom | 32'd1; cfg_init = $urandom; cfg_xorout = $urandom;
          cfg_refin = 1'($urandom); cfg_refout = 1'($urandom);
        end
      endcase
      random_frame();
      send_frame(1'b0, 3, 1'b0, 1'($urandom), 1'b0, 32'h0);
    end

    for (int f = 0; f < 8; f++) begin
      cfg_poly = {16'h0, 16'($urandom) | 16'd1}; cfg_init = {16'h0, 16'($urandom)};
      cfg_xorout = {16'h0, 16'($urandom)};
      cfg_refin = 1'($urandom); cfg_refout = 1'($urandom);
      random_frame();
      send_frame(1'b1, 3, 1'b0, 1'b0, 1'b0, 32'h0);
    end

    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
